// File: rtl/ysyx_23060203_idu_stage_if.sv
// ysyx_23060203_idu_stage_if: fetch-in, EXU-out, flush and writeback signals of the decode stage.
// master drives the stage inputs (fetch/EXU/writeback side), slave is the decode stage itself.
interface ysyx_23060203_idu_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_wen;
    logic        out_illegal;
    modport master (
        output in_valid, in_pc, in_inst, flush, wb_valid, wb_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_imm, out_fmt, out_wen, out_illegal
    );
    modport slave (
        input  in_valid, in_pc, in_inst, flush, wb_valid, wb_rd, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_imm, out_fmt, out_wen, out_illegal
    );
endinterface

// File: rtl/ysyx_23060203_idu_stage.sv
// ysyx_23060203_idu_stage: RV32I decode into a registered uop with a per-register pending-write scoreboard.
// Define IDU_RVE_EN for RV32E: 16 registers, any used register field with bit4 set decodes as illegal.
module ysyx_23060203_idu_stage #(
    parameter int SB_CNT_W = 2,
    parameter int NR_REG   = 32
) (
    input logic clock,
    input logic reset,
    ysyx_23060203_idu_stage_if.slave bus
);
`ifdef IDU_RVE_EN
    localparam int REG_N = 16;
`else
    localparam int REG_N = NR_REG;
`endif
    localparam int AW = $clog2(REG_N);
    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_SYS, F_ILL} fmt_e;
    function automatic logic uses_rs1(fmt_e f);
        return f inside {F_R, F_I, F_S, F_B, F_SYS};
    endfunction
    function automatic logic uses_rs2(fmt_e f);
        return f inside {F_R, F_S, F_B};
    endfunction
    function automatic logic writes_rd(fmt_e f);
        return f inside {F_R, F_I, F_U, F_J, F_SYS};
    endfunction
    logic                valid_q, valid_d, wen_q, wen_d;
    logic [31:0]         pc_q, inst_q, imm_q, imm_d;
    fmt_e                fmt_q, fmt_d;
    logic [SB_CNT_W-1:0] cnt_q [REG_N];
    logic [REG_N-1:0]    inc, dec;
    logic                hazard, out_valid, out_fire, in_ready, in_fire;
    wire  [31:0]         inst = bus.in_inst;
    wire  [2:0]          f3 = inst[14:12];
    wire  [6:0]          f7 = inst[31:25];
    always_comb begin
        case (inst[6:0])
            7'b0110111, 7'b0010111: fmt_d = F_U;
            7'b1101111: fmt_d = F_J;
            7'b1100111: fmt_d = f3 == 3'b000 ? F_I : F_ILL;
            7'b1100011: fmt_d = (f3 == 3'b010 || f3 == 3'b011) ? F_ILL : F_B;
            7'b0000011: fmt_d = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? F_ILL : F_I;
            7'b0100011: fmt_d = f3 <= 3'b010 ? F_S : F_ILL;
            7'b0010011: fmt_d = ((f3 == 3'b001 && f7 != 7'b0) ||
                                 (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)) ? F_ILL : F_I;
            7'b0110011: fmt_d = (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) ? F_R : F_ILL;
            7'b0001111: fmt_d = f3 <= 3'b001 ? F_I : F_ILL;
            7'b1110011: fmt_d = f3 == 3'b100 ? F_ILL : F_SYS;
            default:    fmt_d = F_ILL;
        endcase
`ifdef IDU_RVE_EN
        if ((uses_rs1(fmt_d) && inst[19]) || (uses_rs2(fmt_d) && inst[24]) || (writes_rd(fmt_d) && inst[11]))
            fmt_d = F_ILL;
`endif
        wen_d = writes_rd(fmt_d) && inst[11:7] != 5'd0;
        imm_d = fmt_d inside {F_I, F_SYS} ? {{20{inst[31]}}, inst[31:20]} :
                fmt_d == F_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                fmt_d == F_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                fmt_d == F_U ? {inst[31:12], 12'b0} :
                fmt_d == F_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'd0;
    end
    // Legal uops never carry bit4 in RVE mode, so truncated indices stay in range.
    assign hazard = (uses_rs1(fmt_q) && inst_q[19:15] != 5'd0 && cnt_q[inst_q[15 +: AW]] != '0) ||
                    (uses_rs2(fmt_q) && inst_q[24:20] != 5'd0 && cnt_q[inst_q[20 +: AW]] != '0) ||
                    (wen_q && cnt_q[inst_q[7 +: AW]] == '1);
    assign out_valid = valid_q & ~hazard & ~bus.flush;
    assign out_fire  = out_valid & bus.out_ready;
    assign in_ready  = (~valid_q | out_fire) & ~bus.flush;
    assign in_fire   = bus.in_valid & in_ready;
    assign valid_d   = in_fire | (valid_q & ~out_fire & ~bus.flush);
    always_comb begin
        for (int r = 0; r < REG_N; r++) begin
            inc[r] = out_fire & wen_q & (inst_q[11:7] == 5'(r));
            dec[r] = bus.wb_valid & (bus.wb_rd == 5'(r)) & (r != 0) & (cnt_q[r] != '0);
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            imm_q   <= '0;
            fmt_q   <= F_R;
            wen_q   <= 1'b0;
            for (int r = 0; r < REG_N; r++) cnt_q[r] <= '0;
        end else begin
            valid_q <= valid_d;
            if (in_fire) begin
                pc_q   <= bus.in_pc;
                inst_q <= bus.in_inst;
                imm_q  <= imm_d;
                fmt_q  <= fmt_d;
                wen_q  <= wen_d;
            end
            for (int r = 0; r < REG_N; r++) cnt_q[r] <= cnt_q[r] + SB_CNT_W'(inc[r]) - SB_CNT_W'(dec[r]);
        end
    end
    wb_to_idle_reg: assert property (@(posedge clock) disable iff (!reset)
        bus.wb_valid && bus.wb_rd != 5'd0 && int'(bus.wb_rd) < REG_N |-> cnt_q[bus.wb_rd[AW-1:0]] != '0);
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = pc_q;
    assign bus.out_inst    = inst_q;
    assign bus.out_rs1     = inst_q[19:15];
    assign bus.out_rs2     = inst_q[24:20];
    assign bus.out_rd      = inst_q[11:7];
    assign bus.out_imm     = imm_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_wen     = wen_q;
    assign bus.out_illegal = fmt_q == F_ILL;
endmodule

// File: tb/tb_ysyx_23060203_idu_stage.sv
// tb_ysyx_23060203_idu_stage: directed decode/scoreboard/flush scenarios with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ysyx_23060203_idu_stage;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    ysyx_23060203_idu_stage_if bus ();
    ysyx_23060203_idu_stage dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1   = 32'h0010_8133;
    localparam logic [31:0] LUI_X5      = 32'h1234_52B7;
    localparam logic [31:0] JAL_X1_M8   = 32'hFF9F_F0EF;
    localparam logic [31:0] BEQ_M4      = 32'hFE00_0EE3;
    localparam logic [31:0] ADD_X6_X5   = 32'h0002_8333;
    localparam logic [31:0] SW_X2_8_X1  = 32'h0020_A423;
    localparam logic [31:0] CSRRW_X0    = 32'h3003_1073;
    localparam logic [31:0] ADDI_X0_M1  = 32'hFFF0_0013;
    localparam logic [31:0] MUL_X2      = 32'h0210_8133;

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.flush = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.out_ready = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clock); bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_inst = inst;
        @(negedge clock); bus.in_valid = 1'b0; #1;
    endtask

    task automatic retire(input logic [4:0] rd);
        @(negedge clock); bus.wb_valid = 1'b1; bus.wb_rd = rd;
        @(negedge clock); bus.wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%h exp=0", bus.out_valid); end
        n_chk++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); end
        n_chk++; if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst got=%h exp=0", bus.out_inst); end
        n_chk++; if (bus.out_fmt !== 3'd0) begin n_fail++; $display("FAIL rst_out_fmt got=%h exp=0", bus.out_fmt); end
        n_chk++; if (bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL rst_out_wen got=%h exp=0", bus.out_wen); end
        repeat (2) @(negedge clock);
        reset = 1'b1; #1;
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%h exp=1", bus.in_ready); end
    endtask

    task automatic test_addi();
        send(32'h8000_0000, ADDI_X1_5);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%h exp=1", bus.out_valid); end
        n_chk++; if (bus.out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL addi_pc got=%h exp=80000000", bus.out_pc); end
        n_chk++; if (bus.out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got=%h exp=5", bus.out_imm); end
        n_chk++; if (bus.out_fmt !== 3'd1) begin n_fail++; $display("FAIL addi_fmt got=%h exp=1", bus.out_fmt); end
        n_chk++; if (bus.out_wen !== 1'b1) begin n_fail++; $display("FAIL addi_wen got=%h exp=1", bus.out_wen); end
        n_chk++; if (bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", bus.out_rd, bus.out_rs1); end
        n_chk++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got=%h exp=0", bus.out_illegal); end
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got=%h exp=1", bus.in_ready); end
        @(negedge clock); #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained got=%h exp=0", bus.out_valid); end
        retire(5'd1);
    endtask

    task automatic test_back_to_back();
        @(negedge clock); bus.in_valid = 1'b1; bus.in_pc = 32'h100; bus.in_inst = ADDI_X1_5;
        @(negedge clock); bus.in_pc = 32'h104; bus.in_inst = ADD_X2_X1; #1;
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin n_fail++; $display("FAIL b2b_first got valid=%h pc=%h exp 1/100", bus.out_valid, bus.out_pc); end
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%h exp=1", bus.in_ready); end
        @(negedge clock); bus.in_valid = 1'b0; #1;
        n_chk++; if (bus.out_pc !== 32'h104 || bus.out_fmt !== 3'd0) begin n_fail++; $display("FAIL b2b_latched got pc=%h fmt=%0d exp 104/0", bus.out_pc, bus.out_fmt); end
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d got valid=%h in_ready=%h exp 0/0", i, bus.out_valid, bus.in_ready); end
            @(negedge clock); #1;
        end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got=%h exp=0", bus.out_valid); end
        @(negedge clock); bus.wb_valid = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_release got=%h exp=1", bus.out_valid); end
        n_chk++; if (bus.out_rd !== 5'd2 || bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd1) begin n_fail++; $display("FAIL raw_regs got %0d/%0d/%0d exp 2/1/1", bus.out_rd, bus.out_rs1, bus.out_rs2); end
        retire(5'd2);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(32'h200, LUI_X5);
        bus.in_valid = 1'b1; bus.in_pc = 32'h204; bus.in_inst = JAL_X1_M8;
        n_chk++; if (bus.out_imm !== 32'h1234_5000 || bus.out_fmt !== 3'd4) begin n_fail++; $display("FAIL lui_decode got imm=%h fmt=%0d exp 12345000/4", bus.out_imm, bus.out_fmt); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d got valid=%h in_ready=%h exp 1/0", i, bus.out_valid, bus.in_ready); end
            n_chk++; if (bus.out_pc !== 32'h200 || bus.out_inst !== LUI_X5) begin n_fail++; $display("FAIL bp_stable%0d got pc=%h inst=%h exp 200/%h", i, bus.out_pc, bus.out_inst, LUI_X5); end
            if (i < 3) begin @(negedge clock); #1; end
        end
        bus.out_ready = 1'b1; #1;
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%h exp=1", bus.in_ready); end
        @(negedge clock); bus.in_valid = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204) begin n_fail++; $display("FAIL jal_valid got valid=%h pc=%h exp 1/204", bus.out_valid, bus.out_pc); end
        n_chk++; if (bus.out_imm !== 32'hFFFF_FFF8 || bus.out_fmt !== 3'd5) begin n_fail++; $display("FAIL jal_decode got imm=%h fmt=%0d exp fffffff8/5", bus.out_imm, bus.out_fmt); end
        n_chk++; if (bus.out_wen !== 1'b1 || bus.out_rd !== 5'd1) begin n_fail++; $display("FAIL jal_wen got wen=%h rd=%0d exp 1/1", bus.out_wen, bus.out_rd); end
        retire(5'd5);
        retire(5'd1);
        send(32'h208, ADD_X6_X5);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_sb_untouched got=%h exp=1", bus.out_valid); end
        retire(5'd6);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        send(32'h300, BEQ_M4);
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_fmt !== 3'd3) begin n_fail++; $display("FAIL beq_valid got valid=%h fmt=%0d exp 1/3", bus.out_valid, bus.out_fmt); end
        n_chk++; if (bus.out_imm !== 32'hFFFF_FFFC || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL beq_decode got imm=%h wen=%h exp fffffffc/0", bus.out_imm, bus.out_wen); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_inst = ADDI_X1_5; bus.out_ready = 1'b1; #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_mask got valid=%h in_ready=%h exp 0/0", bus.out_valid, bus.in_ready); end
        @(negedge clock); bus.flush = 1'b0; bus.in_valid = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got valid=%h in_ready=%h exp 0/1", bus.out_valid, bus.in_ready); end
        send(32'h308, ADD_X2_X1);
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h308) begin n_fail++; $display("FAIL flush_sb_untouched got valid=%h pc=%h exp 1/308", bus.out_valid, bus.out_pc); end
        retire(5'd2);
    endtask

    task automatic test_sb_full();
        logic [31:0] addi_x3;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            addi_x3 = {12'(i), 20'h00193};
            bus.in_valid = 1'b1; bus.in_pc = 32'h400 + 32'(4 * i); bus.in_inst = addi_x3;
            #1;
            if (i > 1) begin
                n_chk++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'(i - 1)) begin n_fail++; $display("FAIL sb_issue%0d got valid=%h imm=%h exp 1/%0d", i - 1, bus.out_valid, bus.out_imm, i - 1); end
            end
        end
        @(negedge clock); bus.in_valid = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'd4) begin n_fail++; $display("FAIL sb_full_stall got valid=%h imm=%h exp 0/4", bus.out_valid, bus.out_imm); end
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sb_full_in_ready got=%h exp=0", bus.in_ready); end
        @(negedge clock); bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sb_full_wb_cycle got=%h exp=0", bus.out_valid); end
        @(negedge clock); bus.wb_valid = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'd4) begin n_fail++; $display("FAIL sb_full_release got valid=%h imm=%h exp 1/4", bus.out_valid, bus.out_imm); end
        repeat (3) retire(5'd3);
    endtask

    task automatic test_formats();
        send(32'h600, SW_X2_8_X1);
        n_chk++; if (bus.out_fmt !== 3'd2 || bus.out_imm !== 32'd8 || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL sw_decode got fmt=%0d imm=%h wen=%h exp 2/8/0", bus.out_fmt, bus.out_imm, bus.out_wen); end
        n_chk++; if (bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sw_regs got rs1=%0d rs2=%0d valid=%h exp 1/2/1", bus.out_rs1, bus.out_rs2, bus.out_valid); end
        send(32'h604, CSRRW_X0);
        n_chk++; if (bus.out_fmt !== 3'd6 || bus.out_imm !== 32'h300 || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL csr_decode got fmt=%0d imm=%h wen=%h exp 6/300/0", bus.out_fmt, bus.out_imm, bus.out_wen); end
        send(32'h608, ADDI_X0_M1);
        n_chk++; if (bus.out_fmt !== 3'd1 || bus.out_imm !== 32'hFFFF_FFFF || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL addi_x0_decode got fmt=%0d imm=%h wen=%h exp 1/ffffffff/0", bus.out_fmt, bus.out_imm, bus.out_wen); end
        send(32'h60C, 32'hFFFF_FFFF);
        n_chk++; if (bus.out_illegal !== 1'b1 || bus.out_fmt !== 3'd7 || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL ill_ones got ill=%h fmt=%0d wen=%h exp 1/7/0", bus.out_illegal, bus.out_fmt, bus.out_wen); end
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_issued got=%h exp=1", bus.out_valid); end
        send(32'h610, MUL_X2);
        n_chk++; if (bus.out_illegal !== 1'b1 || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL ill_funct7 got ill=%h wen=%h exp 1/0", bus.out_illegal, bus.out_wen); end
`ifdef IDU_RVE_EN
        send(32'h614, 32'h0020_88B3);
        n_chk++; if (bus.out_illegal !== 1'b1 || bus.out_wen !== 1'b0) begin n_fail++; $display("FAIL rve_x17 got ill=%h wen=%h exp 1/0", bus.out_illegal, bus.out_wen); end
`endif
    endtask

    task automatic test_reset_mid();
        send(32'h500, ADDI_X1_5);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_issue got=%h exp=1", bus.out_valid); end
        @(negedge clock); reset = 1'b0; #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_clear got valid=%h in_ready=%h pc=%h exp 0/1/0", bus.out_valid, bus.in_ready, bus.out_pc); end
        @(negedge clock); reset = 1'b1;
        send(32'h504, ADD_X2_X1);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_sb_cleared got=%h exp=1", bus.out_valid); end
        retire(5'd2);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_sb_full();
        test_formats();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
